ysyx_25030081_lsu: RTL and testbench

//  Sequential load/store unit between EXU and the data-memory bus, replacing the single-cycle DPI data port.

---
 rtl/ysyx_25030081_lsu.sv | 175 +++++++++++++++++
 tb/tb_ysyx_25030081_lsu.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25030081_lsu.sv
// rtl/ysyx_25030081_lsu.sv - sequential load/store unit between EXU/WBU and the data-memory bus
module ysyx_25030081_lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wen,
    input  logic [2:0]              req_op,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_wen,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic [DATA_WIDTH-1:0]   mem_req_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_req_wstrb,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_resp_rdata,
    input  logic                    mem_resp_err
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int LW = $clog2(NB);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    state_t          state;
    logic [7:0]      cnt;
    logic            wen_q;
    logic [2:0]      op_q;
    logic [LW-1:0]   lane_q;

    logic [LW-1:0]         lane;
    logic [2:0]            align_mask;
    logic [7:0]            strb_base;
    logic [DATA_WIDTH-1:0] size_mask;
    logic                  illegal;
    logic                  misaligned;
    logic [DATA_WIDTH-1:0] rd_shift;
    logic [DATA_WIDTH-1:0] rd_ext;

    assign lane      = req_addr[LW-1:0];
    assign req_ready = (state == S_IDLE);

    always_comb begin
        strb_base  = 8'h01;
        size_mask  = DATA_WIDTH'(64'hFF);
        align_mask = 3'b000;
        case (req_op[1:0])
            2'b00: begin
                strb_base  = 8'h01;
                size_mask  = DATA_WIDTH'(64'hFF);
                align_mask = 3'b000;
            end
            2'b01: begin
                strb_base  = 8'h03;
                size_mask  = DATA_WIDTH'(64'hFFFF);
                align_mask = 3'b001;
            end
            2'b10: begin
                strb_base  = 8'h0F;
                size_mask  = DATA_WIDTH'(64'hFFFF_FFFF);
                align_mask = 3'b011;
            end
            default: begin
                strb_base  = 8'hFF;
                size_mask  = '1;
                align_mask = 3'b111;
            end
        endcase
    end

    // Doubleword ops (D, WU) only exist on the 64-bit datapath.
    assign illegal    = (req_op == 3'b111) ||
                        ((DATA_WIDTH == 32) && (req_op == 3'b011 || req_op == 3'b110));
    assign misaligned = (req_addr[2:0] & align_mask) != 3'b000;

    assign rd_shift = mem_resp_rdata >> {lane_q, 3'b000};

    always_comb begin
        rd_ext = rd_shift;
        case (op_q)
            3'b000:  rd_ext = DATA_WIDTH'($signed(rd_shift[7:0]));
            3'b001:  rd_ext = DATA_WIDTH'($signed(rd_shift[15:0]));
            3'b010:  rd_ext = DATA_WIDTH'($signed(rd_shift[31:0]));
            3'b100:  rd_ext = DATA_WIDTH'(rd_shift[7:0]);
            3'b101:  rd_ext = DATA_WIDTH'(rd_shift[15:0]);
            3'b110:  rd_ext = DATA_WIDTH'(rd_shift[31:0]);
            default: rd_ext = rd_shift;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cnt           <= 8'd0;
            wen_q         <= 1'b0;
            op_q          <= 3'b000;
            lane_q        <= '0;
            resp_valid    <= 1'b0;
            resp_err      <= 1'b0;
            resp_rdata    <= '0;
            mem_req_valid <= 1'b0;
            mem_req_wen   <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wstrb <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        wen_q  <= req_wen;
                        op_q   <= req_op;
                        lane_q <= lane;
                        if (illegal || misaligned) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state         <= S_ADDR;
                            mem_req_valid <= 1'b1;
                            mem_req_wen   <= req_wen;
                            mem_req_addr  <= req_addr & ~ADDR_WIDTH'(NB - 1);
                            mem_req_wdata <= req_wen ? ((req_wdata & size_mask) << {lane, 3'b000}) : '0;
                            mem_req_wstrb <= req_wen ? (NB'(strb_base) << lane) : '0;
                        end
                    end
                end
                S_ADDR: begin
                    if (mem_req_ready) begin
                        state         <= S_DATA;
                        cnt           <= 8'd0;
                        mem_req_valid <= 1'b0;
                        mem_req_wen   <= 1'b0;
                        mem_req_addr  <= '0;
                        mem_req_wdata <= '0;
                        mem_req_wstrb <= '0;
                    end
                end
                S_DATA: begin
                    if (mem_resp_valid) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= mem_resp_err;
                        resp_rdata <= (wen_q || mem_resp_err) ? '0 : rd_ext;
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state      <= S_IDLE;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_25030081_lsu.sv
// tb/tb_ysyx_25030081_lsu.sv - bench for ysyx_25030081_lsu on 32- and 64-bit datapaths
module tb_ysyx_25030081_lsu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        req_valid, req_wen, resp_ready, mem_req_ready, mem_resp_valid, mem_resp_err;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [63:0] req_wdata, mem_resp_rdata;

    logic        a_req_ready, a_resp_valid, a_resp_err, a_mvalid, a_mwen;
    logic [31:0] a_rdata, a_maddr, a_mwdata;
    logic [3:0]  a_mstrb;
    logic        b_req_ready, b_resp_valid, b_resp_err, b_mvalid, b_mwen;
    logic [63:0] b_rdata, b_mwdata;
    logic [31:0] b_maddr;
    logic [7:0]  b_mstrb;

    logic        c_req_ready, c_resp_valid, c_resp_err, c_mvalid, c_mwen;
    logic [63:0] c_rdata, c_mwdata;
    logic [31:0] c_maddr;
    logic [7:0]  c_mstrb;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ysyx_25030081_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) u32 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
        .req_wen(req_wen), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .resp_valid(a_resp_valid), .resp_ready(resp_ready), .resp_rdata(a_rdata), .resp_err(a_resp_err),
        .mem_req_valid(a_mvalid), .mem_req_ready(mem_req_ready), .mem_req_wen(a_mwen),
        .mem_req_addr(a_maddr), .mem_req_wdata(a_mwdata), .mem_req_wstrb(a_mstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata[31:0]), .mem_resp_err(mem_resp_err)
    );

    ysyx_25030081_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT(8)) u64 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid & sel), .req_ready(b_req_ready),
        .req_wen(req_wen), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(resp_ready), .resp_rdata(b_rdata), .resp_err(b_resp_err),
        .mem_req_valid(b_mvalid), .mem_req_ready(mem_req_ready), .mem_req_wen(b_mwen),
        .mem_req_addr(b_maddr), .mem_req_wdata(b_mwdata), .mem_req_wstrb(b_mstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err)
    );

    assign c_req_ready  = sel ? b_req_ready  : a_req_ready;
    assign c_resp_valid = sel ? b_resp_valid : a_resp_valid;
    assign c_resp_err   = sel ? b_resp_err   : a_resp_err;
    assign c_mvalid     = sel ? b_mvalid     : a_mvalid;
    assign c_mwen       = sel ? b_mwen       : a_mwen;
    assign c_rdata      = sel ? b_rdata      : {32'd0, a_rdata};
    assign c_mwdata     = sel ? b_mwdata     : {32'd0, a_mwdata};
    assign c_maddr      = sel ? b_maddr      : a_maddr;
    assign c_mstrb      = sel ? b_mstrb      : {4'd0, a_mstrb};

    typedef struct {
        logic        s;
        logic        w;
        logic [2:0]  op;
        logic [31:0] a;
        logic [63:0] wd;
        logic [63:0] word;
        logic        be;
        logic        xbus;
        logic        xerr;
        logic [63:0] xrd;
        logic [7:0]  xstrb;
        logic [63:0] xwd;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: byte-by-byte view of the access, independent of any shifter structure.
    task automatic model(input int dw, input logic w, input logic [2:0] op, input logic [31:0] a,
                         input logic [63:0] wd, input logic [63:0] word, input logic be,
                         output logic xbus, output logic xerr, output logic [63:0] xrd,
                         output logic [7:0] xstrb, output logic [63:0] xwd);
        int sz, nb, lane;
        logic [63:0] v;
        sz   = 1 << op[1:0];
        nb   = dw / 8;
        lane = int'(a % nb);
        xbus = !((op == 3'd7) || (dw == 32 && (op == 3'd3 || op == 3'd6)) || ((a % sz) != 0));
        xerr = !xbus || be;
        xstrb = '0;
        xwd   = '0;
        xrd   = '0;
        if (xbus && w) begin
            for (int b = 0; b < sz; b++) begin
                xstrb[lane + b] = 1'b1;
                xwd[(lane + b) * 8 +: 8] = wd[b * 8 +: 8];
            end
        end
        if (!w && !xerr) begin
            v = '0;
            for (int b = 0; b < sz; b++) v[b * 8 +: 8] = word[(lane + b) * 8 +: 8];
            if (!op[2] && sz < 8 && v[sz * 8 - 1])
                for (int b = sz; b < 8; b++) v[b * 8 +: 8] = 8'hFF;
            xrd = (dw == 32) ? (v & 64'hFFFF_FFFF) : v;
        end
    endtask

    task automatic do_txn(input vec_t v, input int rdy_stall, input int rsp_stall);
        logic [63:0] bm;
        logic [31:0] xaddr;
        bm = '0;
        for (int b = 0; b < 8; b++) bm[b * 8 +: 8] = v.xstrb[b] ? 8'hFF : 8'h00;
        xaddr = v.s ? (v.a & ~32'd7) : (v.a & ~32'd3);
        @(negedge clk);
        sel = v.s; req_wen = v.w; req_op = v.op; req_addr = v.a; req_wdata = v.wd; req_valid = 1'b1;
        #1 chk("req_ready_idle", c_req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        if (!v.xbus) begin
            chk("err_no_bus", c_mvalid, 1'b0);
        end else begin
            chk("mreq_valid", c_mvalid, 1'b1);
            chk("early_resp", c_resp_valid, 1'b0);
            chk("mreq_addr", c_maddr, xaddr);
            chk("mreq_wen", c_mwen, v.w);
            chk("mreq_wstrb", c_mstrb, v.xstrb);
            if (v.w) chk("mreq_wdata", c_mwdata & bm, v.xwd);
            for (int i = 0; i < rdy_stall; i++) begin
                @(negedge clk);
                chk("stall_valid", c_mvalid, 1'b1);
                chk("stall_addr", c_maddr, xaddr);
                chk("stall_strb", c_mstrb, v.xstrb);
            end
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            chk("mreq_drop", c_mvalid, 1'b0);
            chk("resp_latency", c_resp_valid, 1'b0);
            mem_resp_valid = 1'b1; mem_resp_rdata = v.word; mem_resp_err = v.be;
            @(negedge clk);
            mem_resp_valid = 1'b0; mem_resp_err = 1'b0; mem_resp_rdata = {$urandom, $urandom};
        end
        chk("resp_valid", c_resp_valid, 1'b1);
        chk("resp_err", c_resp_err, v.xerr);
        chk("resp_rdata", c_rdata, v.xrd);
        chk("busy_ready", c_req_ready, 1'b0);
        for (int i = 0; i < rsp_stall; i++) begin
            @(negedge clk);
            chk("hold_valid", c_resp_valid, 1'b1);
            chk("hold_rdata", c_rdata, v.xrd);
            chk("hold_busy", c_req_ready, 1'b0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("resp_done", c_resp_valid, 1'b0);
        chk("idle_again", c_req_ready, 1'b1);
    endtask

    vec_t tbl[14];

    initial begin
        vec_t v;
        tbl[0]  = '{0, 0, 3'b000, 32'h8000_0003, 64'h0, 64'h8011_2233, 0, 1, 0, 64'hFFFF_FF80, 8'h00, 64'h0};
        tbl[1]  = '{0, 1, 3'b001, 32'h8000_0002, 64'hBEEF, 64'h0, 0, 1, 0, 64'h0, 8'h0C, 64'hBEEF_0000};
        tbl[2]  = '{0, 0, 3'b010, 32'h8000_0002, 64'h0, 64'h0, 0, 0, 1, 64'h0, 8'h00, 64'h0};
        tbl[3]  = '{0, 0, 3'b111, 32'h8000_0000, 64'h0, 64'h0, 0, 0, 1, 64'h0, 8'h00, 64'h0};
        tbl[4]  = '{0, 0, 3'b011, 32'h8000_0000, 64'h0, 64'h0, 0, 0, 1, 64'h0, 8'h00, 64'h0};
        tbl[5]  = '{0, 0, 3'b010, 32'h8000_0004, 64'h0, 64'h1234_5678, 1, 1, 1, 64'h0, 8'h00, 64'h0};
        tbl[6]  = '{0, 0, 3'b101, 32'h8000_0002, 64'h0, 64'h8001_0000, 0, 1, 0, 64'h8001, 8'h00, 64'h0};
        tbl[7]  = '{1, 0, 3'b011, 32'h8000_0008, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 1, 0,
                    64'h0123_4567_89AB_CDEF, 8'h00, 64'h0};
        tbl[8]  = '{1, 0, 3'b110, 32'h8000_0004, 64'h0, 64'hFFFF_FFFF_0000_0000, 0, 1, 0,
                    64'h0000_0000_FFFF_FFFF, 8'h00, 64'h0};
        tbl[9]  = '{1, 0, 3'b001, 32'h8000_0002, 64'h0, 64'h0000_0000_8001_0000, 0, 1, 0,
                    64'hFFFF_FFFF_FFFF_8001, 8'h00, 64'h0};
        tbl[10] = '{1, 1, 3'b010, 32'h8000_0004, 64'hCAFE_F00D, 64'h0, 0, 1, 0, 64'h0, 8'hF0,
                    64'hCAFE_F00D_0000_0000};
        tbl[11] = '{1, 0, 3'b110, 32'h8000_0002, 64'h0, 64'h0, 0, 0, 1, 64'h0, 8'h00, 64'h0};
        tbl[12] = '{1, 0, 3'b111, 32'h8000_0000, 64'h0, 64'h0, 0, 0, 1, 64'h0, 8'h00, 64'h0};
        tbl[13] = '{0, 1, 3'b000, 32'h8000_0001, 64'hA5, 64'h0, 0, 1, 0, 64'h0, 8'h02, 64'h0000_A500};

        rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_op = 3'b000;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_rdata = '0; mem_resp_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", c_req_ready, 1'b1);
        chk("rst_resp_valid", c_resp_valid, 1'b0);
        chk("rst_mvalid", c_mvalid, 1'b0);
        chk("rst_maddr", c_maddr, 32'h0);
        chk("rst_rdata", c_rdata, 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) do_txn(tbl[i], (i == 1) ? 2 : 0, (i == 0) ? 3 : 0);

        for (int i = 0; i < 40; i++) begin
            int sz;
            v.s  = 1'($urandom % 2);
            v.w  = 1'($urandom % 2);
            v.op = 3'($urandom % 8);
            v.a  = 32'h8000_0000 | ($urandom % 64);
            sz   = 1 << v.op[1:0];
            if ($urandom % 4 != 0) v.a = v.a & ~(32'(sz) - 32'd1);
            v.wd   = {$urandom, $urandom};
            v.word = {$urandom, $urandom};
            v.be   = ($urandom % 8 == 0);
            model(v.s ? 64 : 32, v.w, v.op, v.a, v.wd, v.word, v.be, v.xbus, v.xerr, v.xrd, v.xstrb, v.xwd);
            do_txn(v, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        // Stalled request, then a bus that never answers.
        @(negedge clk);
        sel = 1'b0; req_wen = 1'b0; req_op = 3'b010; req_addr = 32'h8000_0010; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("to_stall_valid", c_mvalid, 1'b1);
            chk("to_stall_addr", c_maddr, 32'h8000_0010);
            chk("to_stall_strb", c_mstrb, 8'h00);
            @(negedge clk);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("to_not_yet", c_resp_valid, 1'b0);
            @(negedge clk);
        end
        chk("to_valid", c_resp_valid, 1'b1);
        chk("to_err", c_resp_err, 1'b1);
        chk("to_rdata", c_rdata, 64'h0);
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'h1234_5678; mem_resp_err = 1'b0;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk("late_err_kept", c_resp_err, 1'b1);
        chk("late_rdata_kept", c_rdata, 64'h0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        mem_resp_valid = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk("idle_pulse_resp", c_resp_valid, 1'b0);
        chk("idle_pulse_mreq", c_mvalid, 1'b0);
        chk("idle_pulse_ready", c_req_ready, 1'b1);

        // Reset while waiting in S_DATA abandons the access.
        @(negedge clk);
        sel = 1'b0; req_wen = 1'b1; req_op = 3'b010; req_addr = 32'h8000_0020; req_wdata = 64'h55; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_resp", c_resp_valid, 1'b0);
        chk("mid_rst_err", c_resp_err, 1'b0);
        chk("mid_rst_mreq", c_mvalid, 1'b0);
        chk("mid_rst_strb", c_mstrb, 8'h00);
        chk("mid_rst_ready", c_req_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_quiet", c_resp_valid, 1'b0);
        do_txn(tbl[0], 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
